vga_scanline_buffer: RTL and testbench



---
 rtl/vga_scanline_buffer.sv | 159 +++++++++++++++
 tb/tb_vga_scanline_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanline_buffer.sv
// rtl/vga_scanline_buffer.sv - 2x-scaled 256x192 VDP window over 640x480 VGA from a ping-pong line buffer (optional SCANLINE_EN)
module vga_scanline_buffer #(
    parameter int H_OFFSET = 64,
    parameter int V_OFFSET = 48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_column,
    input  logic [9:0]  pixel_row,
    input  logic        video_on,
    input  logic        horiz_sync,
    input  logic        vert_sync,
    input  logic [3:0]  backdrop,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [3:0]  wr_data,
    output logic        line_req,
    output logic [7:0]  req_line,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        video_on_o
);

    localparam logic [9:0] H_LO   = 10'(H_OFFSET);
    localparam logic [9:0] H_HI   = 10'(H_OFFSET + 511);
    localparam logic [9:0] V_LO   = 10'(V_OFFSET);
    localparam logic [9:0] V_HI   = 10'(V_OFFSET + 383);
    localparam bit         PRE_EN = (V_OFFSET >= 2);
    localparam logic [9:0] V_PRE  = PRE_EN ? 10'(V_OFFSET - 2) : 10'd0;

    // stage 1: registered timing inputs
    logic [9:0] col1, row1;
    logic       von1, hs1, vs1;
    logic [3:0] bd1;

    // stage 2: RAM read data and aligned controls
    logic [3:0] rd_data, bd2;
    logic       in_win2, von2, hs2, vs2, odd2;

    logic [9:0] dx, dy;
    logic [7:0] sx1, sl1;
    logic       in_win1;
    logic       req_hit;
    logic [7:0] req_val;
    logic [3:0] pal_idx;
    logic [11:0] pix_rgb;

    logic [3:0] line_ram [0:511];

    always_comb begin
        dx      = col1 - H_LO;
        dy      = row1 - V_LO;
        sx1     = 8'(dx >> 1);
        sl1     = 8'(dy >> 1);
        in_win1 = von1 && (col1 >= H_LO) && (col1 <= H_HI)
                       && (row1 >= V_LO) && (row1 <= V_HI);
    end

    // source line n+1 is requested on the first display row of source line n
    always_comb begin
        req_hit = 1'b0;
        req_val = 8'd0;
        if (col1 == 10'd0) begin
            if (PRE_EN && row1 == V_PRE) begin
                req_hit = 1'b1;
                req_val = 8'd0;
            end else if (row1 >= V_LO && !dy[0] && dy < 10'd382) begin
                req_hit = 1'b1;
                req_val = sl1 + 8'd1;
            end
        end
    end

    function automatic logic [11:0] palette(input logic [3:0] idx);
        case (idx)
            4'h0: palette = 12'h000;
            4'h1: palette = 12'h000;
            4'h2: palette = 12'h2C3;
            4'h3: palette = 12'h5D6;
            4'h4: palette = 12'h22E;
            4'h5: palette = 12'h45F;
            4'h6: palette = 12'hB44;
            4'h7: palette = 12'h4DF;
            4'h8: palette = 12'hF44;
            4'h9: palette = 12'hF77;
            4'hA: palette = 12'hDC4;
            4'hB: palette = 12'hED8;
            4'hC: palette = 12'h2B2;
            4'hD: palette = 12'hC5B;
            4'hE: palette = 12'hCCC;
            default: palette = 12'hFFF;
        endcase
    endfunction

    always_comb begin
        pal_idx = (in_win2 && rd_data != 4'd0) ? rd_data : bd2;
        pix_rgb = palette(pal_idx);
`ifdef SCANLINE_EN
        if (in_win2 && odd2)
            pix_rgb = {1'b0, pix_rgb[11:9], 1'b0, pix_rgb[7:5], 1'b0, pix_rgb[3:1]};
`endif
    end

    // write port is free-running; RAM contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en)
            line_ram[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col1       <= '0;
            row1       <= '0;
            von1       <= 1'b0;
            hs1        <= 1'b1;
            vs1        <= 1'b1;
            bd1        <= '0;
            rd_data    <= '0;
            bd2        <= '0;
            in_win2    <= 1'b0;
            von2       <= 1'b0;
            hs2        <= 1'b1;
            vs2        <= 1'b1;
            odd2       <= 1'b0;
            rgb        <= '0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
            video_on_o <= 1'b0;
            line_req   <= 1'b0;
            req_line   <= '0;
        end else begin
            col1       <= pixel_column;
            row1       <= pixel_row;
            von1       <= video_on;
            hs1        <= horiz_sync;
            vs1        <= vert_sync;
            bd1        <= backdrop;

            rd_data    <= line_ram[{sl1[0], sx1}];
            bd2        <= bd1;
            in_win2    <= in_win1;
            von2       <= von1;
            hs2        <= hs1;
            vs2        <= vs1;
            odd2       <= dy[0];

            rgb        <= von2 ? pix_rgb : 12'h000;
            hsync_o    <= hs2;
            vsync_o    <= vs2;
            video_on_o <= von2;

            line_req   <= req_hit;
            if (req_hit)
                req_line <= req_val;
        end
    end

endmodule

// File: tb/tb_vga_scanline_buffer.sv
// tb/tb_vga_scanline_buffer.sv - directed self-checking bench for vga_scanline_buffer
module tb_vga_scanline_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  pixel_column = '0;
    logic [9:0]  pixel_row = '0;
    logic        video_on = 1'b0;
    logic        horiz_sync = 1'b1;
    logic        vert_sync = 1'b1;
    logic [3:0]  backdrop = 4'd4;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        line_req;
    logic [7:0]  req_line;
    logic [11:0] rgb;
    logic        hsync_o, vsync_o, video_on_o;

    int total = 0;
    int bad = 0;

    // expected outputs for the last three driven pixels; [2] is due now
    logic [11:0] h_rgb [3];
    logic        h_hs [3];
    logic        h_vs [3];
    logic        h_von [3];
    logic        h_chk [3];
    string       h_tag [3];

    vga_scanline_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .pixel_column(pixel_column), .pixel_row(pixel_row),
        .video_on(video_on), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .backdrop(backdrop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_req(line_req), .req_line(req_line), .rgb(rgb),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .video_on_o(video_on_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            h_chk[i] = 1'b0;
            h_rgb[i] = '0;
            h_hs[i]  = 1'b1;
            h_vs[i]  = 1'b1;
            h_von[i] = 1'b0;
            h_tag[i] = "";
        end
    endtask

    task automatic pix(input string tag, input int col, input int row, input logic von,
                       input logic hs, input logic vs, input logic [11:0] e);
        pixel_column = col[9:0];
        pixel_row    = row[9:0];
        video_on     = von;
        horiz_sync   = hs;
        vert_sync    = vs;
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            h_rgb[i] = h_rgb[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
            h_von[i] = h_von[i-1]; h_chk[i] = h_chk[i-1]; h_tag[i] = h_tag[i-1];
        end
        h_rgb[0] = e; h_hs[0] = hs; h_vs[0] = vs; h_von[0] = von; h_chk[0] = 1'b1; h_tag[0] = tag;
        if (h_chk[2]) begin
            chk({h_tag[2], "_rgb"}, rgb, h_rgb[2]);
            chk({h_tag[2], "_hsync"}, {11'd0, hsync_o}, {11'd0, h_hs[2]});
            chk({h_tag[2], "_vsync"}, {11'd0, vsync_o}, {11'd0, h_vs[2]});
            chk({h_tag[2], "_von"}, {11'd0, video_on_o}, {11'd0, h_von[2]});
        end
    endtask

    task automatic idle();
        pix("idle", 700, 500, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic wr(input logic [8:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        idle();
        wr_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rgb"}, rgb, 12'h000);
        chk({tag, "_hsync"}, {11'd0, hsync_o}, 12'd1);
        chk({tag, "_vsync"}, {11'd0, vsync_o}, 12'd1);
        chk({tag, "_von"}, {11'd0, video_on_o}, 12'd0);
        chk({tag, "_lreq"}, {11'd0, line_req}, 12'd0);
        chk({tag, "_rline"}, {4'd0, req_line}, 12'd0);
    endtask

    int npulse;
    int exp_row;
    logic [11:0] odd_rgb;

    initial begin
        clear_hist();
        // reset state, with activity on the inputs
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        pixel_column = 10'd100; pixel_row = 10'd48; video_on = 1'b1; horiz_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_busy");
        @(negedge clk);
        reset_n = 1'b1;

        // row 0 border with backdrop 4, hsync pulse 656..751
        backdrop = 4'd4;
        for (int c = 0; c < 800; c++)
            pix("row0", c, 0, 1'b1, !(c >= 656 && c < 752), 1'b1, 12'h22E);
        repeat (3) idle();

        wr(9'h000, 4'd6);
        wr(9'h001, 4'd15);
        wr(9'h002, 4'd0);
        wr(9'h003, 4'd6);
        wr(9'h100, 4'd8);
        wr(9'h1FF, 4'd15);

        pix("c63",  63, 48, 1'b1, 1'b1, 1'b1, 12'h22E);
        pix("c64",  64, 48, 1'b1, 1'b1, 1'b1, 12'hB44);
        pix("c65",  65, 48, 1'b1, 1'b1, 1'b1, 12'hB44);
        pix("c66",  66, 48, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix("c67",  67, 48, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix("tr4",  68, 48, 1'b1, 1'b1, 1'b1, 12'h22E);
        backdrop = 4'd0;
        pix("tr0",  68, 48, 1'b1, 1'b1, 1'b1, 12'h000);
        backdrop = 4'd15;
        pix("tr15", 68, 48, 1'b1, 1'b1, 1'b1, 12'hFFF);
        backdrop = 4'd4;
        pix("bank1", 64, 50, 1'b1, 1'b1, 1'b1, 12'hF44);
        pix("lastpx", 575, 431, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix("c576", 576, 48, 1'b1, 1'b1, 1'b1, 12'h22E);
        pix("r432", 64, 432, 1'b1, 1'b1, 1'b1, 12'h22E);
`ifdef SCANLINE_EN
        odd_rgb = 12'h777;
`else
        odd_rgb = 12'hFFF;
`endif
        pix("r49", 66, 49, 1'b1, 1'b1, 1'b1, odd_rgb);
        pix("r49b", 63, 49, 1'b1, 1'b1, 1'b1, 12'h22E);

        // read-before-write on bank 0, x=3
        pix("rbw_old", 70, 48, 1'b1, 1'b1, 1'b1, 12'hB44);
        wr_en = 1'b1; wr_addr = 9'h003; wr_data = 4'd15;
        pix("rbw_new", 70, 48, 1'b1, 1'b1, 1'b1, 12'hFFF);
        wr_en = 1'b0;
        pix("rbw_after", 70, 48, 1'b1, 1'b1, 1'b1, 12'hFFF);
        repeat (3) idle();

        // abbreviated frame: columns 0..3 of every row
        npulse = 0;
        for (int r = 0; r < 520; r++) begin
            for (int c = 0; c < 4; c++) begin
                pix("frame", c, r, r < 480, 1'b1, !(r == 490 || r == 491),
                    (r < 480) ? 12'h22E : 12'h000);
                if (line_req) begin
                    exp_row = (npulse == 0) ? 46 : 48 + 2 * (npulse - 1);
                    chk("req_line", {4'd0, req_line}, 12'(npulse));
                    chk("req_row", 12'(r), 12'(exp_row));
                    chk("req_col", 12'(c), 12'd1);
                    npulse++;
                end
            end
        end
        repeat (3) idle();
        chk("req_count", 12'(npulse), 12'd192);
        chk("req_hold", {4'd0, req_line}, 12'd191);

        // reset mid-frame with a request pending
        pix("pend", 0, 46, 1'b0, 1'b1, 1'b1, 12'h000);
        reset_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        pixel_column = 10'd64; pixel_row = 10'd48; video_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("mid_hold");
        @(negedge clk);
        reset_n = 1'b1;
        clear_hist();
        pix("rel0", 64, 48, 1'b1, 1'b1, 1'b1, 12'hB44);
        pix("rel1", 2, 46, 1'b0, 1'b1, 1'b1, 12'h000);
        pix("rel2", 3, 46, 1'b0, 1'b1, 1'b1, 12'h000);
        chk("lost_req", {11'd0, line_req}, 12'd0);
        pix("rel3", 0, 48, 1'b1, 1'b1, 1'b1, 12'h22E);
        pix("rel4", 1, 48, 1'b1, 1'b1, 1'b1, 12'h22E);
        chk("next_req", {11'd0, line_req}, 12'd1);
        chk("next_line", {4'd0, req_line}, 12'd1);
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
